bus_arbiter: RTL

Two-requester arbiter and sequencer for the single CPU data-access port of the address-decode bus. Instruction fetch (m0) and load/store (m1) each present a request; the arbiter grants one under round-robin, drives the bus access for exactly one cycle from registered command state, and returns registered read data and error to the winner. It sits between the core's fetch/LSU units and the bus decoder, replacing direct core wiring of the `acs_*` port.

---
 rtl/bus_arb_pkg.sv | 15 +
 rtl/rr_arb2.sv | 15 +
 rtl/bus_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the two-master CPU data-access bus arbiter.
package bus_arb_pkg;

  localparam int unsigned N_MASTERS = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic M_IFU = 1'b0;
  localparam logic M_LSU = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, on contention the master not granted last wins.
module rr_arb2
  import bus_arb_pkg::*;
(
  input  logic [N_MASTERS-1:0] req,
  input  logic                 last,
  output logic [N_MASTERS-1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (last == M_LSU) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates fetch (m0) and load/store (m1) onto the single acs_* access port,
// issuing one bus cycle per grant and returning the registered response to the owner.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 64,
  parameter int unsigned SW = 8
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [SW-1:0] m0_bytes,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_error,

  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [SW-1:0] m1_bytes,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_error,

  output logic          acs_en,
  output logic          acs_wr,
  output logic [SW-1:0] acs_bytes,
  output logic [AW-1:0] acs_addr,
  output logic [DW-1:0] acs_wdata,
  input  logic [DW-1:0] acs_rdata,
  input  logic          acs_error
);

  state_e               state_q, state_d;
  logic                 last_q, last_d;
  logic                 owner_q, owner_d;
  logic [N_MASTERS-1:0] arb_gnt, grant;
  logic                 gnt_id;

  logic                 acs_en_d, acs_wr_d;
  logic [SW-1:0]        acs_bytes_d;
  logic [AW-1:0]        acs_addr_d;
  logic [DW-1:0]        acs_wdata_d;
  logic                 m0_rvalid_d, m0_error_d, m1_rvalid_d, m1_error_d;
  logic [DW-1:0]        m0_rdata_d, m1_rdata_d;

  rr_arb2 u_rr_arb2 (
    .req  ({m1_req, m0_req}),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  // Grants are only offered while the bus is not occupied by an issued access.
  assign grant  = (state_q != ISSUE) ? arb_gnt : '0;
  assign gnt_id = grant[1];
  assign m0_gnt = grant[0];
  assign m1_gnt = grant[1];

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    acs_en_d    = 1'b0;
    acs_wr_d    = 1'b0;
    acs_bytes_d = '0;
    acs_addr_d  = '0;
    acs_wdata_d = '0;
    m0_rvalid_d = 1'b0;
    m0_rdata_d  = '0;
    m0_error_d  = 1'b0;
    m1_rvalid_d = 1'b0;
    m1_rdata_d  = '0;
    m1_error_d  = 1'b0;

    case (state_q)
      IDLE, RESP: begin
        if (|grant) begin
          state_d     = ISSUE;
          last_d      = gnt_id;
          owner_d     = gnt_id;
          acs_en_d    = 1'b1;
          acs_wr_d    = (gnt_id == M_LSU) ? m1_wr    : m0_wr;
          acs_bytes_d = (gnt_id == M_LSU) ? m1_bytes : m0_bytes;
          acs_addr_d  = (gnt_id == M_LSU) ? m1_addr  : m0_addr;
          acs_wdata_d = (gnt_id == M_LSU) ? m1_wdata : m0_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        // Capture the bus response for the owner; writes return zero data.
        state_d = RESP;
        if (owner_q == M_IFU) begin
          m0_rvalid_d = 1'b1;
          m0_rdata_d  = acs_wr ? '0 : acs_rdata;
          m0_error_d  = acs_error;
        end else begin
          m1_rvalid_d = 1'b1;
          m1_rdata_d  = acs_wr ? '0 : acs_rdata;
          m1_error_d  = acs_error;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= M_LSU;
      owner_q   <= M_IFU;
      acs_en    <= 1'b0;
      acs_wr    <= 1'b0;
      acs_bytes <= '0;
      acs_addr  <= '0;
      acs_wdata <= '0;
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m0_error  <= 1'b0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
      m1_error  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      acs_en    <= acs_en_d;
      acs_wr    <= acs_wr_d;
      acs_bytes <= acs_bytes_d;
      acs_addr  <= acs_addr_d;
      acs_wdata <= acs_wdata_d;
      m0_rvalid <= m0_rvalid_d;
      m0_rdata  <= m0_rdata_d;
      m0_error  <= m0_error_d;
      m1_rvalid <= m1_rvalid_d;
      m1_rdata  <= m1_rdata_d;
      m1_error  <= m1_error_d;
    end
  end

endmodule
